// File: rtl/lif_spike_decoder.sv
// Spike-train decoder for the LIF neuron: counts rising spike edges over a programmable window
// and tracks the minimum inter-spike interval. The ISI datapath exists only with LIF_DECODER_ISI_EN defined.
module lif_spike_decoder #(
  parameter int CNT_W = 8,
  parameter int WIN_W = 8,
  parameter int ISI_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             spike_in,
  input  logic             start,
  input  logic [WIN_W-1:0] win_len,
  output logic             busy,
  output logic [CNT_W-1:0] rate_out,
  output logic [ISI_W-1:0] isi_min,
  output logic             overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       dbg_state
);

  // Result handshake: a result is transferred on a rising edge where ena, out_valid and out_ready
  // are all high; out_valid then stays high with stable results until that transfer happens.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t           state;
  logic             spike_q;
  logic [WIN_W:0]   win_cnt;
  logic [CNT_W-1:0] cnt_acc;
  logic             ovf_acc;

  logic             spike_edge;
  logic             win_start;
  logic             win_last;
  logic [WIN_W:0]   win_load;
  logic [CNT_W-1:0] cnt_nxt;
  logic             ovf_cnt;
  logic             ovf_isi;
  logic             ovf_nxt;

  assign spike_edge = spike_in & ~spike_q;
  assign win_start  = start & ((state == IDLE) | ((state == HOLD) & out_ready));
  assign win_last   = (state == MEASURE) & (win_cnt == {{WIN_W{1'b0}}, 1'b1});
  // A zero length selects the full 2^WIN_W window, hence the extra counter bit.
  assign win_load   = (win_len == '0) ? {1'b1, {WIN_W{1'b0}}} : {1'b0, win_len};
  assign ovf_nxt    = ovf_acc | ovf_cnt | ovf_isi;
  assign dbg_state  = state;

  always_comb begin
    cnt_nxt = cnt_acc;
    ovf_cnt = 1'b0;
    if (spike_edge) begin
      if (cnt_acc == '1) ovf_cnt = 1'b1;
      else               cnt_nxt = cnt_acc + 1'b1;
    end
  end

`ifdef LIF_DECODER_ISI_EN
  logic [ISI_W-1:0] isi_cnt;
  logic [ISI_W-1:0] isi_acc;
  logic             first_q;
  logic [ISI_W-1:0] isi_cnt_nxt;
  logic [ISI_W-1:0] isi_acc_nxt;

  // The ISI counter holds the distance to the previous edge as seen on the current cycle.
  always_comb begin
    isi_cnt_nxt = isi_cnt;
    isi_acc_nxt = isi_acc;
    ovf_isi     = 1'b0;
    if (spike_edge) begin
      if (!first_q && (isi_cnt < isi_acc)) isi_acc_nxt = isi_cnt;
      isi_cnt_nxt = {{(ISI_W-1){1'b0}}, 1'b1};
    end else if (isi_cnt != '1) begin
      isi_cnt_nxt = isi_cnt + 1'b1;
      ovf_isi     = (isi_cnt_nxt == '1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      isi_cnt <= '0;
      isi_acc <= '1;
      first_q <= 1'b1;
      isi_min <= '1;
    end else if (ena) begin
      if (win_start) begin
        isi_cnt <= '0;
        isi_acc <= '1;
        first_q <= 1'b1;
      end else if (state == MEASURE) begin
        isi_cnt <= isi_cnt_nxt;
        isi_acc <= isi_acc_nxt;
        if (spike_edge) first_q <= 1'b0;
        if (win_last)   isi_min <= isi_acc_nxt;
      end
    end
  end
`else
  assign ovf_isi = 1'b0;
  assign isi_min = '1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      spike_q   <= 1'b0;
      win_cnt   <= '0;
      cnt_acc   <= '0;
      ovf_acc   <= 1'b0;
      busy      <= 1'b0;
      rate_out  <= '0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else if (ena) begin
      spike_q <= spike_in;
      case (state)
        IDLE: ;
        MEASURE: begin
          win_cnt <= win_cnt - 1'b1;
          cnt_acc <= cnt_nxt;
          ovf_acc <= ovf_nxt;
          // The final window cycle's own edge is folded into the latched result.
          if (win_last) begin
            state     <= HOLD;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            rate_out  <= cnt_nxt;
            overflow  <= ovf_nxt;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (win_start) begin
        state   <= MEASURE;
        busy    <= 1'b1;
        win_cnt <= win_load;
        cnt_acc <= '0;
        ovf_acc <= 1'b0;
      end
    end
  end

endmodule
